// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode encodings, FSM state type and shared helpers for alu_mc.
// Optional divider: define ALU_MC_DIV_EN to build DIVU; otherwise 1101 is reserved.
package alu_mc_pkg;

  localparam int ALU_MC_DATA_WIDTH = 32;

  localparam logic [3:0] ALUOP_AND  = 4'b0000;
  localparam logic [3:0] ALUOP_OR   = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_XOR  = 4'b0011;
  localparam logic [3:0] ALUOP_NOR  = 4'b0100;
  localparam logic [3:0] ALUOP_SLTU = 4'b0101;
  localparam logic [3:0] ALUOP_SUB  = 4'b0110;
  localparam logic [3:0] ALUOP_SLT  = 4'b0111;
  localparam logic [3:0] ALUOP_SLL  = 4'b1000;
  localparam logic [3:0] ALUOP_SRL  = 4'b1001;
  localparam logic [3:0] ALUOP_SRA  = 4'b1010;
  localparam logic [3:0] ALUOP_MULU = 4'b1100;
  localparam logic [3:0] ALUOP_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for opcodes that go through the iterative multiply/divide unit.
  function automatic logic is_multi_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == ALUOP_MULU) || (op == ALUOP_DIVU);
`else
    return (op == ALUOP_MULU);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: iterative shift-add multiplier and restoring divider, one
// iteration per cycle for DATA_WIDTH cycles. o_lo/o_hi present the value the
// registers take after the current iteration, so the final result is
// available in the same cycle o_done is high.
// Divider datapath only exists when ALU_MC_DIV_EN is defined.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_MC_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_start,
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic                  o_dbz
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  logic                  r_active;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_opb;
  logic                  r_dbz;
  logic [DATA_WIDTH:0]   w_msum;

  // Multiply step: add multiplicand into the high half when the low bit is set.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

`ifdef ALU_MC_DIV_EN
  logic                  r_is_div;
  logic [DATA_WIDTH:0]   w_dshift;
  logic                  w_dge;
  logic [DATA_WIDTH-1:0] w_dtrial;

  // Divide step: shift next dividend bit into the partial remainder and try
  // subtracting. The difference always fits DATA_WIDTH bits when it is kept.
  assign w_dshift = {r_hi, r_lo[DATA_WIDTH-1]};
  assign w_dge    = (w_dshift >= {1'b0, r_opb});
  assign w_dtrial = w_dshift[DATA_WIDTH-1:0] - r_opb;
`endif

  // Next partial product / partial remainder for this iteration.
  always_comb begin
    o_hi = w_msum[DATA_WIDTH:1];
    o_lo = {w_msum[0], r_lo[DATA_WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    if (r_is_div) begin
      o_hi = w_dge ? w_dtrial : w_dshift[DATA_WIDTH-1:0];
      o_lo = {r_lo[DATA_WIDTH-2:0], w_dge};
    end
`endif
  end

  assign o_done = r_active && (r_cnt == LAST_ITER);
  assign o_dbz  = r_dbz;

  // Operand load on start, then one iteration per cycle until the last one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_dbz    <= 1'b0;
`ifdef ALU_MC_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= i_a;
      r_opb    <= i_b;
      r_dbz    <= i_is_div && (i_b == '0);
`ifdef ALU_MC_DIV_EN
      r_is_div <= i_is_div;
`endif
    end else if (r_active) begin
      r_hi  <= o_hi;
      r_lo  <= o_lo;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops are computed from the inputs at accept and registered;
// MULU (and DIVU when ALU_MC_DIV_EN is defined) run in alu_mc_muldiv.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no result pending, ready for an operation
// ST_BUSY | iterative multiply/divide in progress, inputs not accepted
// ST_DONE | result registered, out_valid high until consumed
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_MC_DATA_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_multi;
  logic                  w_md_done;
  logic                  w_md_dbz;
  logic [DATA_WIDTH-1:0] w_md_lo;
  logic [DATA_WIDTH-1:0] w_md_hi;

  logic [DATA_WIDTH:0]   w_add;
  logic [DATA_WIDTH:0]   w_sub;
  logic                  w_add_ovf;
  logic                  w_sub_ovf;
  logic                  w_borrow;
  logic                  w_slt;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;
  logic                  w_cry;

  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_result_hi;
  logic                  r_ovf;
  logic                  r_cry;

  assign w_multi = is_multi_op(ALUop);

  // Overflow is carry into the MSB xor carry out of it; borrow is inverted carry.
  assign w_add     = {1'b0, A} + {1'b0, B};
  assign w_sub     = {1'b0, A} + {1'b0, ~B} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1] ^ w_add[DATA_WIDTH-1]) ^ w_add[DATA_WIDTH];
  assign w_sub_ovf = (A[DATA_WIDTH-1] ^ ~B[DATA_WIDTH-1] ^ w_sub[DATA_WIDTH-1]) ^ w_sub[DATA_WIDTH];
  assign w_borrow  = ~w_sub[DATA_WIDTH];
  assign w_slt     = w_sub_ovf ^ w_sub[DATA_WIDTH-1];

  // Single-cycle result and flags; reserved opcodes fall through to zero.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_cry = 1'b0;
    case (ALUop)
      ALUOP_AND:  w_res = A & B;
      ALUOP_OR:   w_res = A | B;
      ALUOP_XOR:  w_res = A ^ B;
      ALUOP_NOR:  w_res = ~(A | B);
      ALUOP_ADD: begin
        w_res = w_add[DATA_WIDTH-1:0];
        w_ovf = w_add_ovf;
        w_cry = w_add[DATA_WIDTH];
      end
      ALUOP_SUB: begin
        w_res = w_sub[DATA_WIDTH-1:0];
        w_ovf = w_sub_ovf;
        w_cry = w_borrow;
      end
      ALUOP_SLT: begin
        w_res = {{(DATA_WIDTH-1){1'b0}}, w_slt};
        w_cry = w_borrow;
      end
      ALUOP_SLTU: begin
        w_res = {{(DATA_WIDTH-1){1'b0}}, w_borrow};
        w_cry = w_borrow;
      end
      ALUOP_SLL:  w_res = A << B[SHAMT_WIDTH-1:0];
      ALUOP_SRL:  w_res = A >> B[SHAMT_WIDTH-1:0];
      ALUOP_SRA:  w_res = DATA_WIDTH'($signed(A) >>> B[SHAMT_WIDTH-1:0]);
      default: ;
    endcase
  end

  // Handshake outputs and next state; in_ready is held low during reset.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = resetn;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = resetn & out_ready;
      end
      default: ;
    endcase
    w_accept = in_valid & in_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_multi ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_md_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)       w_state_nxt = w_multi ? ST_BUSY : ST_DONE;
        else if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Output registers: load on single-cycle accept or on iterative completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_ovf       <= 1'b0;
      r_cry       <= 1'b0;
    end else if (w_accept && !w_multi) begin
      r_result    <= w_res;
      r_result_hi <= '0;
      r_ovf       <= w_ovf;
      r_cry       <= w_cry;
    end else if (w_md_done) begin
      r_result    <= w_md_lo;
      r_result_hi <= w_md_hi;
      r_ovf       <= w_md_dbz;
      r_cry       <= 1'b0;
    end
  end

  alu_mc_muldiv #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .resetn   (resetn),
    .i_start  (w_accept & w_multi),
    .i_is_div (ALUop == ALUOP_DIVU),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_md_done),
    .o_lo     (w_md_lo),
    .o_hi     (w_md_hi),
    .o_dbz    (w_md_dbz)
  );

  assign Result   = r_result;
  assign ResultHi = r_result_hi;
  assign Overflow = r_ovf;
  assign CarryOut = r_cry;
  assign Zero     = (r_result == '0);

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at DATA_WIDTH=32. Expected results
// are computed by a reference model when an operation is driven and checked
// when the DUT hands the result over.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALUop = '0;
  logic         in_ready, out_valid, Overflow, CarryOut, Zero;
  logic [W-1:0] Result, ResultHi;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         cry;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp, m_got;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  alu_mc dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ResultHi  (ResultHi),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [4:0]     sh;
    logic           lt;
    e  = '0;
    sh = b[4:0];
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_NOR: e.res = ~(a | b);
      OP_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.cry = s[W];
        e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        e.res = a - b;
        e.cry = (a < b);
        e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      OP_SLT: begin
        lt    = ($signed(a) < $signed(b));
        e.res = {{(W-1){1'b0}}, lt};
        e.cry = (a < b);
      end
      OP_SLTU: begin
        lt    = (a < b);
        e.res = {{(W-1){1'b0}}, lt};
        e.cry = lt;
      end
      OP_SLL: e.res = a << sh;
      OP_SRL: e.res = a >> sh;
      OP_SRA: e.res = W'($signed(a) >>> sh);
      OP_MULU: begin
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
      end
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        if (b == '0) begin
          e.res = '1;
          e.hi  = a;
          e.ovf = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
`endif
      default: ;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: a result is handed over when out_valid & out_ready at the next edge.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      m_got = {Result, ResultHi, Overflow, CarryOut, Zero};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got res=%h hi=%h, want no result", Result, ResultHi);
      end else begin
        m_exp = sb.pop_front();
        if (m_got !== m_exp) begin
          n_err++;
          $display("FAIL result: got res=%h hi=%h ovf=%b cry=%b z=%b, want res=%h hi=%h ovf=%b cry=%b z=%b",
                   Result, ResultHi, Overflow, CarryOut, Zero,
                   m_exp.res, m_exp.hi, m_exp.ovf, m_exp.cry, m_exp.zero);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operation and hold it until accepted; returns cycles stalled.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    waited   = 0;
    ALUop    = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    sb.push_back(model(op, a, b));
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1 || waited > 200) break;
      waited++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
  endtask

  task automatic drain(output bit ok);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    ok = (sb.size() == 0);
  endtask

  // Cycles from the accept edge until out_valid is seen high.
  task automatic latency(output int k, output int busy_rdy);
    k        = 0;
    busy_rdy = 0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid && in_ready) busy_rdy++;
    end while (!out_valid && k < 100);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_vec++; if (Result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", Result); end
    n_vec++; if (ResultHi !== '0) begin n_err++; $display("FAIL reset_result_hi: got %h want 0", ResultHi); end
    n_vec++; if ({Overflow, CarryOut} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got ovf=%b cry=%b want 0 0", Overflow, CarryOut); end
    n_vec++; if (Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", Zero); end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_latency;
    int w, k, br;
    bit ok;
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, w);
    latency(k, br);
    n_vec++; if (k !== 1) begin n_err++; $display("FAIL add_latency: got %0d cycles want 1", k); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_add: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_alu_ops;
    int w;
    bit ok;
    send(OP_SUB,  32'h0000_0000, 32'h0000_0001, w);
    send(OP_SLT,  32'h8000_0000, 32'h0000_0001, w);
    send(OP_SLTU, 32'h8000_0000, 32'h0000_0001, w);
    send(OP_SRA,  32'h8000_0000, 32'h0000_0004, w);
    send(OP_SRA,  32'h8000_0000, 32'hFFFF_FFE4, w);
    send(OP_SRL,  32'h8000_0000, 32'h0000_001F, w);
    send(OP_SLL,  32'h0000_0001, 32'h0000_003F, w);
    send(OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, w);
    send(OP_OR,   32'hF0F0_1234, 32'h0F00_0001, w);
    send(OP_XOR,  32'hAAAA_5555, 32'hFFFF_FFFF, w);
    send(OP_NOR,  32'h0000_0000, 32'h0000_0000, w);
    send(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, w);
    send(OP_ADD,  32'h8000_0000, 32'h8000_0000, w);
    send(OP_SUB,  32'h8000_0000, 32'h0000_0001, w);
    send(OP_SUB,  32'h0000_0005, 32'h0000_0005, w);
    send(OP_SLT,  32'h0000_0001, 32'h8000_0000, w);
    send(OP_SLTU, 32'h0000_0001, 32'h8000_0000, w);
    send(4'b1011, 32'h1234_5678, 32'h0000_0003, w);
    send(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    send(4'b1111, 32'h0000_0001, 32'h0000_0002, w);
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_alu_ops: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_mulu;
    int w, k, br;
    bit ok;
    send(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    latency(k, br);
    n_vec++; if (k !== 33) begin n_err++; $display("FAIL mulu_latency: got %0d cycles want 33", k); end
    n_vec++; if (br !== 0) begin n_err++; $display("FAIL mulu_busy_in_ready: got %0d ready cycles want 0", br); end
    send(OP_MULU, 32'h0001_0000, 32'h0001_0000, w);
    send(OP_MULU, $urandom, $urandom, w);
    send(OP_MULU, 32'h0000_0000, 32'hDEAD_BEEF, w);
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_mulu: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_divu;
    int w, k, br, lat;
    bit ok;
`ifdef ALU_MC_DIV_EN
    lat = 33;
`else
    lat = 1;
`endif
    send(OP_DIVU, 32'd100, 32'd7, w);
    latency(k, br);
    n_vec++; if (k !== lat) begin n_err++; $display("FAIL divu_latency: got %0d cycles want %0d", k, lat); end
    send(OP_DIVU, 32'd5, 32'd0, w);
    send(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, w);
    send(OP_DIVU, 32'd3, 32'd9, w);
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_divu: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    int   w;
    exp_t e;
    e = model(OP_AND, 32'hF0F0_A5A5, 32'hFF00_0FF0);
    out_ready = 1'b0;
    send(OP_AND, 32'hF0F0_A5A5, 32'hFF00_0FF0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {Result, ResultHi, Overflow, CarryOut, Zero} !== e) begin
        n_err++;
        $display("FAIL backpressure_hold: got v=%b rdy=%b res=%h hi=%h, want v=1 rdy=0 res=%h hi=%h",
                 out_valid, in_ready, Result, ResultHi, e.res, e.hi);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int w, stalls, c0;
    bit ok;
    stalls    = 0;
    out_ready = 1'b1;
    c0        = cyc;
    for (int i = 0; i < 10; i++) begin
      send(4'($urandom_range(0, 10)), $urandom, $urandom, w);
      stalls += w;
    end
    n_vec++; if (stalls !== 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    n_vec++; if (cyc - c0 !== 10) begin n_err++; $display("FAIL b2b_cycles: got %0d want 10", cyc - c0); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_b2b: got %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_mulu;
    int w, k, br;
    bit ok;
    send(OP_ADD, 32'd1, 32'd1, w);
    drain(ok);
    send(OP_MULU, 32'h1234_5678, 32'h09AB_CDEF, w);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (Result !== '0) begin n_err++; $display("FAIL midreset_result: got %h want 0", Result); end
    n_vec++; if (Zero !== 1'b1) begin n_err++; $display("FAIL midreset_zero: got %b want 1", Zero); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
    sb.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ADD, 32'd3, 32'd4, w);
    latency(k, br);
    n_vec++; if (k !== 1) begin n_err++; $display("FAIL midreset_add_latency: got %0d want 1", k); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL drain_midreset: got %0d outstanding want 0", sb.size()); end
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_alu_ops();
    test_mulu();
    test_divu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mulu();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
